dmem_lsu: RTL and testbench

- Load/store initiator that drives the single-port, 1-cycle-read-latency data memory (en/we/addr/wdata/rdata, 14-bit word address, 32-bit data) from the pipeline's memory stage.
- Accepts byte/halfword/word requests over a valid/ready handshake and returns one response per request.
- Sub-word stores are done as read-modify-write, because the memory has no byte enables.
- Loads are sign- or zero-extended.

---
 rtl/lsu_pkg.sv | 10 +
 rtl/dmem_lsu_if.sv | 21 ++
 rtl/lsu_lane.sv | 25 ++
 rtl/dmem_lsu.sv | 116 +++++++++++
 tb/tb_dmem_lsu.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared sizes, states and error decode for the dmem load/store unit
package lsu_pkg;
    localparam int LSU_ADDR_W = 14;
    localparam int LSU_DATA_W = 32;
    typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_ILL = 2'b11} size_e;
    typedef enum logic [1:0] {IDLE, RD, WAIT, WR} state_e;
    function automatic logic lsu_err(input logic [1:0] size, input logic [1:0] off);
        return (size == SZ_ILL) || (size == SZ_HALF && off[0]) || (size == SZ_WORD && off != 2'b00);
    endfunction
endpackage

// File: rtl/dmem_lsu_if.sv
// dmem_lsu_if: pipeline-side request/response bus of the load/store unit
interface dmem_lsu_if #(parameter int ADDR_W = lsu_pkg::LSU_ADDR_W);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W+1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/lsu_lane.sv
// lsu_lane: little-endian lane extract/extend for loads and lane merge for sub-word stores
module lsu_lane import lsu_pkg::*; (
    input  logic [31:0] mem_rdata,
    input  logic [31:0] wdata,
    input  logic [1:0]  off,
    input  size_e       size,
    input  logic        sgn,
    output logic [31:0] ld_data,
    output logic [31:0] st_data
);
    logic [4:0]  sh;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] mask;
    always_comb begin
        sh = (size == SZ_BYTE) ? {off, 3'b000} : {off[1], 4'b0000};
        b = mem_rdata[{off, 3'b000} +: 8];
        h = off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ld_data = (size == SZ_BYTE) ? {{24{sgn & b[7]}}, b} :
                  (size == SZ_HALF) ? {{16{sgn & h[15]}}, h} : mem_rdata;
        mask = (size == SZ_BYTE) ? (32'h0000_00ff << sh) :
               (size == SZ_HALF) ? (32'h0000_ffff << sh) : 32'hffff_ffff;
        st_data = (mem_rdata & ~mask) | ((wdata << sh) & mask);
    end
endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store initiator for a 1-cycle-latency single-port data memory
module dmem_lsu import lsu_pkg::*; #(
    parameter int ADDR_W = LSU_ADDR_W,
    parameter int DATA_W = LSU_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_lsu_if.slave         bus,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    state_e            state, state_n;
    logic              we_q, sgn_q;
    size_e             size_q;
    logic [1:0]        off_q;
    logic [31:0]       wdata_q;
    logic              accept;
    logic              mem_en_n, mem_we_n, resp_valid_n, resp_err_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [31:0]       mem_wdata_n, resp_rdata_n, ld_data, st_data;

    assign bus.req_ready = (state == IDLE);
    assign accept = bus.req_ready && bus.req_valid;

    lsu_lane u_lane (
        .mem_rdata (mem_rdata),
        .wdata     (wdata_q),
        .off       (off_q),
        .size      (size_q),
        .sgn       (sgn_q),
        .ld_data   (ld_data),
        .st_data   (st_data)
    );

    always_comb begin
        state_n = state;
        mem_en_n = 1'b0;
        mem_we_n = 1'b0;
        mem_addr_n = mem_addr;
        mem_wdata_n = mem_wdata;
        resp_valid_n = 1'b0;
        resp_rdata_n = '0;
        resp_err_n = 1'b0;
        case (state)
            IDLE: if (accept) begin
                if (lsu_err(bus.req_size, bus.req_addr[1:0])) begin
                    resp_valid_n = 1'b1;
                    resp_err_n = 1'b1;
                end else begin
                    mem_addr_n = bus.req_addr[ADDR_W+1:2];
                    // sub-word stores go through a read first: no byte enables on the memory
                    if (bus.req_we && bus.req_size == SZ_WORD) begin
                        state_n = WR;
                        mem_we_n = 1'b1;
                        mem_wdata_n = bus.req_wdata;
                    end else begin
                        state_n = RD;
                        mem_en_n = 1'b1;
                    end
                end
            end
            RD: state_n = WAIT;
            WAIT: if (we_q) begin
                state_n = WR;
                mem_we_n = 1'b1;
                mem_wdata_n = st_data;
            end else begin
                state_n = IDLE;
                resp_valid_n = 1'b1;
                resp_rdata_n = ld_data;
            end
            WR: begin
                state_n = IDLE;
                resp_valid_n = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_err <= 1'b0;
            we_q <= 1'b0;
            sgn_q <= 1'b0;
            size_q <= SZ_BYTE;
            off_q <= 2'b00;
            wdata_q <= '0;
        end else begin
            state <= state_n;
            mem_en <= mem_en_n;
            mem_we <= mem_we_n;
            mem_addr <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            bus.resp_valid <= resp_valid_n;
            bus.resp_rdata <= resp_rdata_n;
            bus.resp_err <= resp_err_n;
            if (accept) begin
                we_q <= bus.req_we;
                sgn_q <= bus.req_signed;
                size_q <= size_e'(bus.req_size);
                off_q <= bus.req_addr[1:0];
                wdata_q <= bus.req_wdata;
            end
        end
    end
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed self-checking bench for dmem_lsu with a behavioural 1-cycle memory
module tb_dmem_lsu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        mem_en, mem_we;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [31:0] mem [0:(1<<14)-1];
    int          we_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    dmem_lsu_if #(.ADDR_W(14)) lsu_bus ();

    dmem_lsu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (lsu_bus.slave),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) mem_rdata <= mem[mem_addr];
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            we_cnt <= we_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // issue one request at a negedge, trace mem_en/mem_we per cycle Cn, check response
    task automatic xfer(input string tag, input logic we, input logic [1:0] size, input logic sgn,
                        input logic [15:0] addr, input logic [31:0] wd, input int lat,
                        input logic [7:0] en_m, input logic [7:0] we_m, input logic [31:0] rd, input logic er);
        logic [7:0] en_t, we_t;
        int n, w;
        en_t = '0;
        we_t = '0;
        w = 0;
        while (!lsu_bus.req_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        lsu_bus.req_valid = 1'b1;
        lsu_bus.req_we = we;
        lsu_bus.req_size = size;
        lsu_bus.req_signed = sgn;
        lsu_bus.req_addr = addr;
        lsu_bus.req_wdata = wd;
        @(negedge clk);
        lsu_bus.req_valid = 1'b0;
        n = 1;
        while (!lsu_bus.resp_valid && n < 7) begin
            en_t[n] = mem_en;
            we_t[n] = mem_we;
            @(negedge clk);
            n++;
        end
        en_t[n] = mem_en;
        we_t[n] = mem_we;
        check({tag, ":lat"}, n, lat);
        check({tag, ":rdata"}, lsu_bus.resp_rdata, rd);
        check({tag, ":err"}, {31'b0, lsu_bus.resp_err}, {31'b0, er});
        check({tag, ":en_trace"}, {24'b0, en_t}, {24'b0, en_m});
        check({tag, ":we_trace"}, {24'b0, we_t}, {24'b0, we_m});
        @(negedge clk);
        check({tag, ":pulse"}, {31'b0, lsu_bus.resp_valid}, 32'd0);
    endtask

    initial begin
        int we0, r1, r2;
        logic [31:0] d1, d2;
        logic rdy1;
        lsu_bus.req_valid = 1'b0;
        lsu_bus.req_we = 1'b0;
        lsu_bus.req_size = 2'b00;
        lsu_bus.req_signed = 1'b0;
        lsu_bus.req_addr = '0;
        lsu_bus.req_wdata = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst:ready", {31'b0, lsu_bus.req_ready}, 32'd1);
        check("rst:en_we_resp", {29'b0, mem_en, mem_we, lsu_bus.resp_valid}, 32'd0);
        check("rst:addr", {18'b0, mem_addr}, 32'd0);
        check("rst:wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        xfer("st_w", 1, 2'b10, 0, 16'h0010, 32'h1122_3344, 2, 8'h00, 8'h02, 32'h0, 0);
        check("st_w:mem", mem[4], 32'h1122_3344);
        xfer("ld_w", 0, 2'b10, 0, 16'h0010, 32'h0, 3, 8'h02, 8'h00, 32'h1122_3344, 0);
        xfer("st_b", 1, 2'b00, 0, 16'h0013, 32'h0000_00AA, 4, 8'h02, 8'h08, 32'h0, 0);
        check("st_b:mem", mem[4], 32'hAA22_3344);
        xfer("ld_bs", 0, 2'b00, 1, 16'h0013, 32'h0, 3, 8'h02, 8'h00, 32'hFFFF_FFAA, 0);
        xfer("ld_bu", 0, 2'b00, 0, 16'h0013, 32'h0, 3, 8'h02, 8'h00, 32'h0000_00AA, 0);

        xfer("st_w2", 1, 2'b10, 0, 16'h0010, 32'h8001_7FFF, 2, 8'h00, 8'h02, 32'h0, 0);
        xfer("ld_hs", 0, 2'b01, 1, 16'h0012, 32'h0, 3, 8'h02, 8'h00, 32'hFFFF_8001, 0);
        xfer("ld_hu", 0, 2'b01, 0, 16'h0012, 32'h0, 3, 8'h02, 8'h00, 32'h0000_8001, 0);
        xfer("ld_hlo", 0, 2'b01, 1, 16'h0010, 32'h0, 3, 8'h02, 8'h00, 32'h0000_7FFF, 0);
        xfer("ld_b1", 0, 2'b00, 1, 16'h0011, 32'h0, 3, 8'h02, 8'h00, 32'h0000_007F, 0);
        xfer("ld_b3", 0, 2'b00, 1, 16'h0013, 32'h0, 3, 8'h02, 8'h00, 32'hFFFF_FF80, 0);
        xfer("ld_ws", 0, 2'b10, 1, 16'h0010, 32'h0, 3, 8'h02, 8'h00, 32'h8001_7FFF, 0);
        xfer("st_h", 1, 2'b01, 0, 16'h0012, 32'h1234_BEEF, 4, 8'h02, 8'h08, 32'h0, 0);
        check("st_h:mem", mem[4], 32'hBEEF_7FFF);
        xfer("st_b0", 1, 2'b00, 0, 16'h0010, 32'hFFFF_FF5A, 4, 8'h02, 8'h08, 32'h0, 0);
        check("st_b0:mem", mem[4], 32'hBEEF_7F5A);

        xfer("err_h", 0, 2'b01, 0, 16'h0011, 32'h0, 1, 8'h00, 8'h00, 32'h0, 1);
        xfer("err_w", 0, 2'b10, 0, 16'h0012, 32'h0, 1, 8'h00, 8'h00, 32'h0, 1);
        xfer("err_sz", 0, 2'b11, 0, 16'h0010, 32'h0, 1, 8'h00, 8'h00, 32'h0, 1);
        xfer("err_st", 1, 2'b10, 0, 16'h0013, 32'hDEAD_BEEF, 1, 8'h00, 8'h00, 32'h0, 1);
        check("err_st:mem", mem[4], 32'hBEEF_7F5A);

        xfer("st_w3", 1, 2'b10, 0, 16'h0020, 32'hCAFE_F00D, 2, 8'h00, 8'h02, 32'h0, 0);
        we0 = we_cnt;
        lsu_bus.req_valid = 1'b1;
        lsu_bus.req_we = 1'b1;
        lsu_bus.req_size = 2'b00;
        lsu_bus.req_addr = 16'h0021;
        lsu_bus.req_wdata = 32'h0000_0055;
        @(negedge clk);
        lsu_bus.req_valid = 1'b0;
        check("abort:rd", {31'b0, mem_en}, 32'd1);
        @(negedge clk);
        check("abort:wait", {30'b0, mem_en, mem_we}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort:en_we_resp", {29'b0, mem_en, mem_we, lsu_bus.resp_valid}, 32'd0);
        check("abort:addr", {18'b0, mem_addr}, 32'd0);
        check("abort:wdata", mem_wdata, 32'd0);
        check("abort:rdata_err", {lsu_bus.resp_rdata[30:0], lsu_bus.resp_err}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort:we_cnt", we_cnt, we0);
        check("abort:mem", mem[8], 32'hCAFE_F00D);
        check("abort:ready", {31'b0, lsu_bus.req_ready}, 32'd1);

        xfer("st_w4", 1, 2'b10, 0, 16'h0040, 32'h0102_0304, 2, 8'h00, 8'h02, 32'h0, 0);
        xfer("st_w5", 1, 2'b10, 0, 16'h0044, 32'hA5A5_A5A5, 2, 8'h00, 8'h02, 32'h0, 0);
        r1 = 0;
        r2 = 0;
        d1 = '0;
        d2 = '0;
        rdy1 = 1'b0;
        lsu_bus.req_valid = 1'b1;
        lsu_bus.req_we = 1'b0;
        lsu_bus.req_size = 2'b10;
        lsu_bus.req_signed = 1'b0;
        lsu_bus.req_addr = 16'h0040;
        for (int n = 1; n <= 9 && r2 == 0; n++) begin
            @(negedge clk);
            if (n == 1) lsu_bus.req_addr = 16'h0044;
            if (lsu_bus.resp_valid) begin
                if (r1 == 0) begin
                    r1 = n;
                    d1 = lsu_bus.resp_rdata;
                    rdy1 = lsu_bus.req_ready;
                end else begin
                    r2 = n;
                    d2 = lsu_bus.resp_rdata;
                    lsu_bus.req_valid = 1'b0;
                end
            end
        end
        lsu_bus.req_valid = 1'b0;
        check("b2b:r1", r1, 3);
        check("b2b:ready_at_r1", {31'b0, rdy1}, 32'd1);
        check("b2b:d1", d1, 32'h0102_0304);
        check("b2b:r2", r2, 6);
        check("b2b:d2", d2, 32'hA5A5_A5A5);
        repeat (3) @(negedge clk);
        check("b2b:idle", {30'b0, lsu_bus.req_ready, lsu_bus.resp_valid}, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
